// File: rtl/reg_update_arbiter_if.sv
// Requester-side bus of reg_update_arbiter: enable, requests, burst locks, words,
// plus the grant and shared-register outputs.
interface reg_update_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8
) ();
  localparam int unsigned SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                  en;
  logic [N_REQ-1:0]      req;
  logic [N_REQ-1:0]      lock;
  logic [N_REQ*DW-1:0]   wdata;
  logic [N_REQ-1:0]      gnt;
  logic [DW-1:0]         q;
  logic                  q_valid;
  logic [SW-1:0]         q_src;
  logic                  busy;

  modport master (
    output en, req, lock, wdata,
    input  gnt, q, q_valid, q_src, busy
  );

  modport slave (
    input  en, req, lock, wdata,
    output gnt, q, q_valid, q_src, busy
  );
endinterface

// File: rtl/reg_update_arbiter.sv
// Round-robin arbiter with burst locking that sequences which requester loads the
// shared register q, with a post-reset hold-off window and a global enable.
module reg_update_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned HOLDOFF   = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  reg_update_arbiter_if.slave bus
);

  localparam int unsigned PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HCW = $clog2(HOLDOFF + 1);
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  generate
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("reg_update_arbiter: N_REQ must be in 2..8");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
      $error("reg_update_arbiter: HOLDOFF must be >= 1");
    end
    if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("reg_update_arbiter: MAX_BURST must be >= 1");
    end
  endgenerate

  // First set bit of r scanning upward from start with wrap; returns {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [PW-1:0]    start);
    logic          found;
    logic [PW-1:0] idx;
    int unsigned   k;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(start) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && r[PW'(k)]) begin
        found = 1'b1;
        idx   = PW'(k);
      end
    end
    return {found, idx};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [BCW-1:0]   burst_q, burst_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [DW-1:0]    q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [PW-1:0]    q_src_q, q_src_d;
  logic             busy_q, busy_d;

  logic [DW-1:0]    words [N_REQ];
  logic [N_REQ-1:0] owner_mask;
  logic [PW-1:0]    next_ptr;
  logic [PW:0]      idle_pick;
  logic [PW:0]      rel_pick;
  logic             owner_req;
  logic             burst_cont;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      words[i] = bus.wdata[i*DW +: DW];
    end
  end

  // Arbitration candidates: from the pointer when idle, past the owner on release.
  always_comb begin
    owner_mask = N_REQ'(1) << owner_q;
    next_ptr   = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
    idle_pick  = rr_pick(bus.req, ptr_q);
    rel_pick   = rr_pick(bus.req & ~owner_mask, next_ptr);
    owner_req  = bus.req[owner_q];
    burst_cont = owner_req && bus.lock[owner_q] && bus.en &&
                 (burst_q < BCW'(MAX_BURST - 1));
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    burst_d   = burst_q;
    gnt_d     = gnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    q_src_d   = q_src_q;

    case (state_q)
      ST_HOLD: begin
        gnt_d  = '0;
        hold_d = hold_q + HCW'(1);
        if (hold_q == HCW'(HOLDOFF - 1)) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        gnt_d = '0;
        if (bus.en && idle_pick[PW]) begin
          owner_d = idle_pick[PW-1:0];
          gnt_d   = N_REQ'(1) << idle_pick[PW-1:0];
          burst_d = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (owner_req) begin
          q_d       = words[owner_q];
          q_src_d   = owner_q;
          q_valid_d = 1'b1;
        end
        if (burst_cont) begin
          burst_d = burst_q + BCW'(1);
        end else begin
          // Release: the owner drops to lowest priority for this re-arbitration.
          ptr_d = next_ptr;
          if (bus.en && rel_pick[PW]) begin
            owner_d = rel_pick[PW-1:0];
            gnt_d   = N_REQ'(1) << rel_pick[PW-1:0];
            burst_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_HOLD;
        hold_d  = '0;
      end
    endcase

    busy_d = (state_d == ST_GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      burst_q   <= '0;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_src_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_src_q   <= q_src_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.q_src   = q_src_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_reg_update_arbiter.sv
// Directed test of reg_update_arbiter: hold-off, round-robin rotation, burst limit,
// zero-bubble handover, enable drop and asynchronous reset mid-burst.
module tb_reg_update_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  reg_update_arbiter_if #(.N_REQ(4), .DW(8)) bus_if ();

  reg_update_arbiter #(
    .N_REQ(4), .DW(8), .HOLDOFF(2), .MAX_BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int xfers;

  initial begin
    errors = 0;
    checks = 0;
    rst_n         = 1'b0;
    bus_if.en     = 1'b1;
    bus_if.req    = 4'b1111;
    bus_if.lock   = 4'b0000;
    bus_if.wdata  = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    chk("rst_gnt",    32'(bus_if.gnt), 32'h0);
    chk("rst_q",      32'(bus_if.q), 32'h0);
    chk("rst_qvalid", 32'(bus_if.q_valid), 32'h0);
    chk("rst_qsrc",   32'(bus_if.q_src), 32'h0);
    chk("rst_busy",   32'(bus_if.busy), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Hold-off: two edges with no grant, grant on the third.
    step(); chk("hold_e1_gnt", 32'(bus_if.gnt), 32'h0);
    step(); chk("hold_e2_gnt", 32'(bus_if.gnt), 32'h0);
    step(); chk("first_gnt",   32'(bus_if.gnt), 32'h1);
    chk("first_busy", 32'(bus_if.busy), 32'h1);

    // Round-robin rotation with all requesting and no locks.
    step();
    chk("rr0_q", 32'(bus_if.q), 32'h11); chk("rr0_qv", 32'(bus_if.q_valid), 32'h1);
    chk("rr0_src", 32'(bus_if.q_src), 32'h0); chk("rr0_gnt", 32'(bus_if.gnt), 32'h2);
    step();
    chk("rr1_q", 32'(bus_if.q), 32'h22); chk("rr1_src", 32'(bus_if.q_src), 32'h1);
    chk("rr1_gnt", 32'(bus_if.gnt), 32'h4);
    step();
    chk("rr2_q", 32'(bus_if.q), 32'h33); chk("rr2_src", 32'(bus_if.q_src), 32'h2);
    chk("rr2_gnt", 32'(bus_if.gnt), 32'h8);
    step();
    chk("rr3_q", 32'(bus_if.q), 32'h44); chk("rr3_src", 32'(bus_if.q_src), 32'h3);
    chk("rr3_gnt", 32'(bus_if.gnt), 32'h1);
    step();
    chk("rr4_q", 32'(bus_if.q), 32'h11); chk("rr4_src", 32'(bus_if.q_src), 32'h0);
    chk("rr4_gnt", 32'(bus_if.gnt), 32'h2);

    // Lone locked requester 2: owner 1 drops, handover to 2, then a 4-transfer burst.
    bus_if.req  = 4'b0100;
    bus_if.lock = 4'b0100;
    step();
    chk("drop_qv",  32'(bus_if.q_valid), 32'h0);
    chk("drop_q",   32'(bus_if.q), 32'h11);
    chk("drop_gnt", 32'(bus_if.gnt), 32'h4);
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_if.q_valid === 1'b1 && bus_if.q === 8'h33) xfers++;
      if (i < 3) chk("burst_gnt", 32'(bus_if.gnt), 32'h4);
    end
    chk("burst_xfers", 32'(xfers), 32'd4);
    chk("burst_gap_gnt", 32'(bus_if.gnt), 32'h0);
    step();
    chk("burst_regnt", 32'(bus_if.gnt), 32'h4);
    chk("burst_gap_qv", 32'(bus_if.q_valid), 32'h0);

    // Owner 0 locked with requester 2 waiting: zero-bubble switch after 4 transfers.
    bus_if.req  = 4'b0001;
    bus_if.lock = 4'b0001;
    step();
    chk("to0_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock0_gnt", 32'(bus_if.gnt), 32'h1);
      chk("lock0_q",   32'(bus_if.q), 32'h11);
    end
    step();
    chk("switch_gnt", 32'(bus_if.gnt), 32'h4);
    chk("switch_qv",  32'(bus_if.q_valid), 32'h1);
    step();
    chk("switch_q",   32'(bus_if.q), 32'h33);
    chk("switch_src", 32'(bus_if.q_src), 32'h2);
    chk("back0_gnt",  32'(bus_if.gnt), 32'h1);

    // Enable drops mid-burst: in-flight transfer lands, then no grants.
    bus_if.req = 4'b0001;
    step();
    chk("en_pre_gnt", 32'(bus_if.gnt), 32'h1);
    bus_if.wdata[7:0] = 8'h5A;
    bus_if.en = 1'b0;
    step();
    chk("en_land_q",  32'(bus_if.q), 32'h5A);
    chk("en_land_qv", 32'(bus_if.q_valid), 32'h1);
    chk("en_rel_gnt", 32'(bus_if.gnt), 32'h0);
    chk("en_rel_busy", 32'(bus_if.busy), 32'h0);
    step();
    chk("en_off_gnt", 32'(bus_if.gnt), 32'h0);
    chk("en_off_qv",  32'(bus_if.q_valid), 32'h0);
    step();
    chk("en_off2_gnt", 32'(bus_if.gnt), 32'h0);
    bus_if.en = 1'b1;
    step();
    chk("en_on_gnt", 32'(bus_if.gnt), 32'h1);

    // Async reset mid-burst while gnt=0010 and q=A5.
    bus_if.req  = 4'b0010;
    bus_if.lock = 4'b0010;
    bus_if.wdata[15:8] = 8'hA5;
    step();
    chk("pre_rst_gnt", 32'(bus_if.gnt), 32'h2);
    step();
    chk("pre_rst_q",   32'(bus_if.q), 32'hA5);
    chk("pre_rst_gnt2", 32'(bus_if.gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_q",    32'(bus_if.q), 32'h0);
    chk("arst_gnt",  32'(bus_if.gnt), 32'h0);
    chk("arst_busy", 32'(bus_if.busy), 32'h0);
    chk("arst_qv",   32'(bus_if.q_valid), 32'h0);
    chk("arst_src",  32'(bus_if.q_src), 32'h0);
    step();
    rst_n = 1'b1;
    step(); chk("rehold_e1_gnt", 32'(bus_if.gnt), 32'h0);
    step(); chk("rehold_e2_gnt", 32'(bus_if.gnt), 32'h0);
    step(); chk("rehold_gnt",    32'(bus_if.gnt), 32'h2);
    step();
    chk("rehold_q",  32'(bus_if.q), 32'hA5);
    chk("rehold_qv", 32'(bus_if.q_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
